latency_ram: RTL and testbench

LATENCY_RAM -- requirements
Module: latency_ram

---
 rtl/latency_ram.sv | 186 ++++++++++++++++++
 tb/tb_latency_ram.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/latency_ram.sv
// -----------------------------------------------------------------------------
// latency_ram
//   Word-organised RAM model with a programmable access latency.
//   An access is requested by holding ramREN or ramWEN high. The block reports
//   BUSY for LAT cycles and then ACCESS for exactly one cycle. During ACCESS a
//   read presents its word on ramload, and a write commits ramstore on the edge
//   that ends ACCESS. Both requests high reports ERROR.
//
// Parameters
//   LAT    BUSY cycles per access (1..15)
//   DEPTH  number of 32-bit words (>= 2)
//
// Configuration macro
//   LATENCY_RAM_RANGE_CHECK_EN  when defined, a word index >= DEPTH faults
//                               instead of wrapping modulo DEPTH.
//
// Ports
//   CLK       in   1   clock, rising edge
//   nRST      in   1   asynchronous active-low reset (memory array not cleared)
//   ramREN    in   1   read request, level-held
//   ramWEN    in   1   write request, level-held
//   ramaddr   in  32   byte address, word index = ramaddr[31:2]
//   ramstore  in  32   write data, sampled on the edge ending ACCESS
//   ramload   out 32   read data, valid while ramstate = ACCESS
//   ramstate  out  2   FREE=0, BUSY=1, ACCESS=2, ERROR=3
// -----------------------------------------------------------------------------
module latency_ram #(
    parameter int LAT   = 2,
    parameter int DEPTH = 16384
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] CNT_RELOAD = 4'(LAT - 1);

    // State encoding matches the ramstate encoding one-to-one.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    // Word index folded into the array range; out-of-range indices wrap.
    function automatic logic [IW-1:0] wrap_idx(input logic [29:0] idx);
        return IW'(idx % 30'(DEPTH));
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic [29:0]   idx_q, idx_d;
    logic [31:0]   ramload_q;
    logic          load_s;

    logic          both_s;
    logic          one_s;
    logic          any_s;
    logic          changed_s;
    logic          oob_s;
    logic [IW-1:0] mem_idx_s;
    logic          unused_addr_s;

    logic [31:0]   mem_q [DEPTH];

    assign both_s        = ramREN & ramWEN;
    assign one_s         = ramREN ^ ramWEN;
    assign any_s         = ramREN | ramWEN;
    // A held request whose direction or word index moved must restart.
    assign changed_s     = (ramWEN != op_wr_q) || (ramaddr[31:2] != idx_q);
    assign mem_idx_s     = wrap_idx(idx_q);
    assign unused_addr_s = ^ramaddr[1:0];

`ifdef LATENCY_RAM_RANGE_CHECK_EN
    assign oob_s = (ramaddr[31:2] >= 30'(DEPTH));
`else
    assign oob_s = 1'b0;
`endif

    // State, counter, captured request and read-data registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            idx_q     <= 30'd0;
            ramload_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            if (load_s) begin
                ramload_q <= mem_q[mem_idx_s];
            end
        end
    end

    // Memory array: written only on the edge that ends a write's DONE cycle.
    always_ff @(posedge CLK) begin
        if ((state_q == S_DONE) && op_wr_q) begin
            mem_q[mem_idx_s] <= ramstore;
        end
    end

    // Next-state, counter and capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (both_s) begin
                    state_d = S_FAULT;
                end else if (one_s) begin
                    op_wr_d = ramWEN;
                    idx_d   = ramaddr[31:2];
                    cnt_d   = CNT_RELOAD;
                    state_d = oob_s ? S_FAULT : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!any_s) begin
                    state_d = S_IDLE;
                end else if (both_s) begin
                    state_d = S_FAULT;
                end else if (changed_s) begin
                    op_wr_d = ramWEN;
                    idx_d   = ramaddr[31:2];
                    cnt_d   = CNT_RELOAD;
                    state_d = oob_s ? S_FAULT : S_WAIT;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    load_s  = ~op_wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (both_s || (oob_s && any_s)) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decode from the registered state only.
    always_comb begin
        ramstate = RS_FREE;
        case (state_q)
            S_IDLE:  ramstate = RS_FREE;
            S_WAIT:  ramstate = RS_BUSY;
            S_DONE:  ramstate = RS_ACCESS;
            S_FAULT: ramstate = RS_ERROR;
            default: ramstate = RS_FREE;
        endcase
    end

    assign ramload = ramload_q;

endmodule

// File: tb/tb_latency_ram.sv
module tb_latency_ram;

    localparam int LAT = 2;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int errors = 0;

    latency_ram #(.LAT(LAT), .DEPTH(16384)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        checks++;
        assert (ramstate === exp) else begin
            errors++;
            $error("FAIL %s: ramstate observed=%0d expected=%0d", tag, ramstate, exp);
        end
    endtask

    task automatic chk_load(input string tag, input logic [31:0] exp);
        checks++;
        assert (ramload === exp) else begin
            errors++;
            $error("FAIL %s: ramload observed=%h expected=%h", tag, ramload, exp);
        end
    endtask

    // Full write: BUSY for LAT cycles, ACCESS, then release into FREE.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        ramWEN = 1'b1; ramaddr = a; ramstore = d;
        repeat (LAT + 1) step();
        chk_state({tag, "_access"}, ACCESS);
        ramWEN = 1'b0;
        step();
        chk_state({tag, "_free"}, FREE);
    endtask

    // Full read with expected data check during ACCESS.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ramREN = 1'b1; ramaddr = a;
        repeat (LAT) step();
        chk_state({tag, "_busy"}, BUSY);
        step();
        chk_state({tag, "_access"}, ACCESS);
        chk_load({tag, "_data"}, exp);
        ramREN = 1'b0;
        step();
        chk_state({tag, "_free"}, FREE);
    endtask

    initial begin
        nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0;
        ramaddr = 32'd0; ramstore = 32'd0;
        #23;
        chk_state("reset_state", FREE);
        chk_load("reset_load", 32'h0000_0000);
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // Write 0x100 with per-cycle status, then read it back.
        ramWEN = 1'b1; ramaddr = 32'h100; ramstore = 32'hDEAD_BEEF;
        step(); chk_state("wr100_c1", BUSY);
        step(); chk_state("wr100_c2", BUSY);
        step(); chk_state("wr100_c3", ACCESS);
        ramWEN = 1'b0;
        step(); chk_state("wr100_c4", FREE);
        do_read("rd100", 32'h100, 32'hDEAD_BEEF);
        chk_load("rd100_hold", 32'hDEAD_BEEF);

        // Preload words used below.
        do_write("wr40", 32'h40, 32'h4040_4040);
        do_write("wr44", 32'h44, 32'h4444_4444);
        do_write("wr200", 32'h200, 32'hA5A5_A5A5);
        do_write("wr0", 32'h0, 32'hCAFE_F00D);
        do_write("wr4", 32'h4, 32'h1111_2222);

        // Address change mid-wait restarts the latency.
        ramREN = 1'b1; ramaddr = 32'h40;
        step(); chk_state("restart_c1", BUSY);
        ramaddr = 32'h44;
        step(); chk_state("restart_c2", BUSY);
        step(); chk_state("restart_c3", BUSY);
        step(); chk_state("restart_c4", ACCESS);
        chk_load("restart_data", 32'h4444_4444);
        ramREN = 1'b0;
        step(); chk_state("restart_c5", FREE);

        // Both requests high for three cycles.
        ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h100; ramstore = 32'h0;
        step(); chk_state("fault_c1", ERROR);
        step(); chk_state("fault_c2", ERROR);
        step(); chk_state("fault_c3", ERROR);
        ramREN = 1'b0; ramWEN = 1'b0;
        step(); chk_state("fault_c4", FREE);
        do_read("fault_mem", 32'h100, 32'hDEAD_BEEF);

        // Reset during a write's wait phase drops the write.
        ramWEN = 1'b1; ramaddr = 32'h200; ramstore = 32'h1234_5678;
        step(); chk_state("rstwr_c1", BUSY);
        #2;
        nRST = 1'b0;
        #1;
        chk_state("rstwr_async", FREE);
        chk_load("rstwr_load", 32'h0000_0000);
        ramWEN = 1'b0;
        #1;
        nRST = 1'b1;
        step(); chk_state("rstwr_after", FREE);
        do_read("rstwr_mem", 32'h200, 32'hA5A5_A5A5);

        // Index 16384: faults with range checking, wraps to word 0 otherwise.
`ifdef LATENCY_RAM_RANGE_CHECK_EN
        ramREN = 1'b1; ramaddr = 32'h1_0000;
        step(); chk_state("oob_c1", ERROR);
        step(); chk_state("oob_c2", ERROR);
        step(); chk_state("oob_c3", ERROR);
        ramREN = 1'b0;
        step(); chk_state("oob_c4", FREE);
`else
        do_read("oob_wrap", 32'h1_0000, 32'hCAFE_F00D);
`endif

        // Back-to-back reads with ramREN held high.
        ramREN = 1'b1; ramaddr = 32'h0;
        step(); chk_state("b2b_c1", BUSY);
        step(); chk_state("b2b_c2", BUSY);
        step(); chk_state("b2b_c3", ACCESS);
        chk_load("b2b_d0", 32'hCAFE_F00D);
        ramaddr = 32'h4;
        step(); chk_state("b2b_c4", FREE);
        step(); chk_state("b2b_c5", BUSY);
        step(); chk_state("b2b_c6", BUSY);
        step(); chk_state("b2b_c7", ACCESS);
        chk_load("b2b_d1", 32'h1111_2222);
        ramREN = 1'b0;
        step(); chk_state("b2b_c8", FREE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
